// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and constants for the APB master controller
package apb_pkg;

    localparam int NUM_APB_SLAVES = 4;
    localparam int SLAVE_ID_W     = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    // One-hot slave select for a slave index.
    function automatic logic [NUM_APB_SLAVES-1:0] decode_slave(input logic [SLAVE_ID_W-1:0] id);
        logic [NUM_APB_SLAVES-1:0] sel;
        sel     = '0;
        sel[id] = 1'b1;
        return sel;
    endfunction

endpackage

// File: rtl/apb_timeout_counter.sv
// rtl/apb_timeout_counter.sv - ACCESS-phase wait counter with terminal-count flag
module apb_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic tc_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Clear wins over enable so a new ACCESS phase always starts from zero.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Terminal count: this is the last ACCESS cycle that may still wait.
    assign tc_o = (count_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/apb_master_ctrl.sv
// rtl/apb_master_ctrl.sv - single-outstanding APB master with command/response handshake and timeout
module apb_master_ctrl
    import apb_pkg::*;
#(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [SLAVE_ID_W-1:0]     cmd_slave_id,
    input  logic [ADDR_W-1:0]         cmd_addr,
    input  logic [DATA_W-1:0]         cmd_wdata,
    output logic                      rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic [NUM_APB_SLAVES-1:0] psel,
    output logic                      penable,
    output logic                      pwrite,
    output logic [ADDR_W-1:0]         paddr,
    output logic [DATA_W-1:0]         pwdata,
    input  logic [DATA_W-1:0]         prdata,
    input  logic                      pready
);

    apb_state_t                state_q,     state_d;
    logic [NUM_APB_SLAVES-1:0] sel_q,       sel_d;
    logic                      pwrite_q,    pwrite_d;
    logic [ADDR_W-1:0]         paddr_q,     paddr_d;
    logic [DATA_W-1:0]         pwdata_q,    pwdata_d;
    logic                      rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]         rsp_rdata_q, rsp_rdata_d;
    logic                      rsp_err_q,   rsp_err_d;

    logic tmo_clear;
    logic tmo_enable;
    logic tmo_tc;

    // SETUP always precedes ACCESS, so clearing there resets the count on ACCESS entry.
    assign tmo_clear  = (state_q == SETUP);
    assign tmo_enable = (state_q == ACCESS) && !pready;

    apb_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (tmo_clear),
        .enable_i (tmo_enable),
        .tc_o     (tmo_tc)
    );

    // Next-state and datapath: capture on handshake, complete or abort from ACCESS.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d  = SETUP;
                    sel_d    = decode_slave(cmd_slave_id);
                    pwrite_d = cmd_write;
                    paddr_d  = cmd_addr;
                    pwdata_d = cmd_wdata;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                // pready is checked first so a late ready in the terminal cycle still succeeds.
                if (pready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = pwrite_q ? '0 : prdata;
                    rsp_err_d   = 1'b0;
                end else if (tmo_tc) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // psel is gated by state so it drops the cycle after completion, abort or reset.
    assign cmd_ready = (state_q == IDLE);
    assign psel      = (state_q == IDLE) ? '0 : sel_q;
    assign penable   = (state_q == ACCESS);
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// tb/tb_apb_master_ctrl.sv - self-checking bench for apb_master_ctrl
module tb_apb_master_ctrl;

    localparam int T = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [1:0] cmd_slave_id;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic [3:0] psel;
    logic       penable;
    logic       pwrite;
    logic [7:0] paddr;
    logic [7:0] pwdata;
    logic [7:0] prdata;
    logic       pready;

    int checks = 0;
    int errors = 0;

    apb_master_ctrl #(.ADDR_W(8), .DATA_W(8), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_slave_id(cmd_slave_id), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .prdata(prdata), .pready(pready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic [1:0] id;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        int         waits;
        logic       exp_err;
        logic [7:0] exp_rdata;
        int         exp_lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: the slave answers on ACCESS cycle waits+1 unless the
    // timeout of T ACCESS cycles comes first.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        int   acc;
        r         = v;
        r.exp_err = (v.waits + 1 > T);
        acc       = r.exp_err ? T : v.waits + 1;
        r.exp_lat = 2 + acc;
        r.exp_rdata = (!r.exp_err && !v.wr) ? v.rdata : 8'h00;
        return r;
    endfunction

    // One transfer starting at #1 after an edge with the DUT idle.
    task automatic do_xfer(input vec_t v, input bit noisy);
        int         c;
        bit         done;
        logic [3:0] oh;
        logic [7:0] held;
        oh = 4'b0001 << v.id;
        cmd_valid    = 1'b1;
        cmd_write    = v.wr;
        cmd_slave_id = v.id;
        cmd_addr     = v.addr;
        cmd_wdata    = v.wdata;
        chk("cmd_ready_idle", cmd_ready, 1);
        tick();
        cmd_valid    = noisy ? 1'($urandom) : 1'b0;
        cmd_write    = 1'($urandom);
        cmd_slave_id = 2'($urandom);
        cmd_addr     = 8'($urandom);
        cmd_wdata    = 8'($urandom);
        c = 1;
        done = 0;
        while (!done && c < 40) begin
            if (rsp_valid) begin
                done = 1;
                cmd_valid = 1'b0;
                pready    = 1'b0;
            end else begin
                chk("psel_busy", psel, oh);
                chk("paddr_busy", paddr, v.addr);
                chk("pwrite_busy", pwrite, v.wr);
                chk("pwdata_busy", pwdata, v.wdata);
                chk("cmd_ready_busy", cmd_ready, 0);
                if (c == 1) begin
                    chk("penable_setup", penable, 0);
                    pready = noisy ? 1'($urandom) : 1'b0;
                    prdata = 8'($urandom);
                end else begin
                    chk("penable_access", penable, 1);
                    pready = ((c - 1) == v.waits + 1);
                    prdata = pready ? v.rdata : 8'($urandom);
                end
                tick();
                c++;
            end
        end
        chk("rsp_seen", done, 1);
        chk("latency", c, v.exp_lat);
        chk("rsp_err", rsp_err, v.exp_err);
        chk("rsp_rdata", rsp_rdata, v.exp_rdata);
        chk("psel_done", psel, 0);
        chk("penable_done", penable, 0);
        chk("cmd_ready_done", cmd_ready, 1);
        chk("paddr_hold", paddr, v.addr);
        held = rsp_rdata;
        tick();
        chk("rsp_pulse", rsp_valid, 0);
        chk("rsp_rdata_hold", rsp_rdata, held);
        chk("rsp_err_hold", rsp_err, v.exp_err);
        chk("state_idle", cmd_ready, 1);
    endtask

    vec_t tbl[7];

    initial begin
        vec_t       v;
        int         acc_i;
        int         rsp_n;
        int         last_t;
        bit         hs;
        logic [3:0] oh;

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_slave_id = 2'd0;
        cmd_addr = 8'h00; cmd_wdata = 8'h00; prdata = 8'h00; pready = 1'b0;
        tick();
        tick();
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_pwrite", pwrite, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", rsp_err, 0);
        rst_n = 1'b1;
        tick();
        chk("rst_cmd_ready", cmd_ready, 1);

        //            wr    id    addr   wdata  rdata  waits err   rdata  lat
        tbl[0] = '{1'b1, 2'd1, 8'h10, 8'hA5, 8'h00, 0,  1'b0, 8'h00, 3};
        tbl[1] = '{1'b0, 2'd3, 8'h22, 8'h00, 8'h5C, 3,  1'b0, 8'h5C, 6};
        tbl[2] = '{1'b0, 2'd2, 8'h33, 8'h00, 8'h77, 20, 1'b1, 8'h00, 18};
        tbl[3] = '{1'b0, 2'd0, 8'h44, 8'h00, 8'hC3, 15, 1'b0, 8'hC3, 18};
        tbl[4] = '{1'b1, 2'd0, 8'hFF, 8'h3C, 8'h99, 15, 1'b0, 8'h00, 18};
        tbl[5] = '{1'b1, 2'd2, 8'h01, 8'h66, 8'h00, 16, 1'b1, 8'h00, 18};
        tbl[6] = '{1'b0, 2'd1, 8'h80, 8'h00, 8'h00, 1,  1'b0, 8'h00, 4};
        for (int i = 0; i < 7; i++) begin
            do_xfer(tbl[i], 1'b0);
        end

        for (int i = 0; i < 25; i++) begin
            v.wr    = 1'($urandom);
            v.id    = 2'($urandom);
            v.addr  = 8'($urandom);
            v.wdata = 8'($urandom);
            v.rdata = 8'($urandom);
            v.waits = $urandom_range(0, 20);
            do_xfer(model(v), 1'b1);
        end

        // Back-to-back reads to ids 0..3 with cmd_valid held and pready tied high.
        pready = 1'b1;
        acc_i  = 0;
        rsp_n  = 0;
        last_t = -1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_slave_id = 2'd0; cmd_addr = 8'h50;
        for (int cyc = 0; cyc < 40 && rsp_n < 4; cyc++) begin
            prdata = {4'hA, psel};
            hs = cmd_valid && cmd_ready;
            tick();
            if (hs) begin
                acc_i++;
                if (acc_i < 4) begin
                    cmd_slave_id = 2'(acc_i);
                    cmd_addr     = 8'(8'h50 + acc_i);
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            if (rsp_valid) begin
                oh = 4'b0001 << rsp_n;
                chk("b2b_order", rsp_rdata, {4'hA, oh});
                if (rsp_n > 0) chk("b2b_spacing", cyc - last_t, 3);
                last_t = cyc;
                rsp_n++;
            end
        end
        chk("b2b_count", rsp_n, 4);
        cmd_valid = 1'b0;
        pready    = 1'b0;
        tick();

        // Reset while in ACCESS abandons the transfer silently.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_slave_id = 2'd2; cmd_addr = 8'h2A;
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("rstacc_in_access", penable, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rstacc_rsp_valid", rsp_valid, 0);
        chk("rstacc_psel", psel, 0);
        chk("rstacc_penable", penable, 0);
        tick();
        chk("rstacc_rsp_valid2", rsp_valid, 0);
        chk("rstacc_cmd_ready", cmd_ready, 1);
        v = '{1'b0, 2'd2, 8'h2B, 8'h00, 8'hE1, 2, 1'b0, 8'h00, 0};
        do_xfer(model(v), 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
